timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel memory-mapped timer peripheral on the core's request/response peripheral bus. It replaces the single-counter timer. It provides `N_CH` independent up/down counters of parametrised width and one shared prescaler. Each channel has a compare match, a sticky status flag, a per-channel interrupt line, and three counting modes: free-run, periodic auto-reload and one-shot.

## Interface
- `ADDR_START`, 0: byte address of register word 0.
- `N_CH`, 2: number of channels, 1..16.
- `CNT_W`, `WORD_W`: counter width, 1..`WORD_W`.
- `PRESC_W`, 16: prescaler divisor width, ≤ `WORD_W`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_req_addr` in `ADDR_W`: byte address.
- `i_req_wr_data` in `WORD_W`: write data.
- `i_req_wr_en` in 1: 1 = write, 0 = read.
- `i_req_count` in `MEM_COUNT_W`: access size.
- `o_res_rd_data` out `WORD_W`: read data.
- `o_res_code` out `MEM_CODE_W`: success or error code from the shared memory-code definitions.
- `o_irq` out `N_CH`: per-channel interrupt, level.

## Operation
- Word index k = (`i_req_addr` − `ADDR_START`) / (`WORD_W`/8).
- Channel c uses words 4c..4c+3:
  - CTRL (RW): bit0 `en`, bit1 `down`, bits3:2 `mode` (0 free-run, 1 periodic, 2 one-shot, 3 treated as free-run), bit4 `irq_en`. All other bits read 0.
  - LOAD (RW, `CNT_W`).
  - CMP (RW, `CNT_W`).
  - COUNT: read returns the live count; a write loads the count directly.
- Word 4·`N_CH` is STATUS. Bit c is channel c's sticky match flag. Writing 1 clears that flag; writing 0 has no effect.
- Word 4·`N_CH`+1 is PRESCALE (RW, `PRESC_W`).
- Valid access: full-word `i_req_count`, word-aligned address, k in range.
  - Response is the success code.
  - Fields narrower than `WORD_W` read zero-extended; writes truncate.
- Invalid access (misaligned, sub-word, or out of range): error code, `o_res_rd_data` = 0, no state change.
- Prescaler:
  - Internal counter `pc` increments every cycle.
  - When `pc` == PRESCALE, `tick` = 1 and `pc` returns to 0.
  - A tick therefore occurs every PRESCALE+1 cycles; PRESCALE = 0 ticks every cycle.
  - Writing PRESCALE also clears `pc`.
- On a tick, each channel with `en` = 1 does the following:
  - If count == CMP (value before the step), it is a match:
    - Set flag[c].
    - free-run: step normally.
    - periodic: count ← LOAD.
    - one-shot: count ← LOAD and `en` ← 0.
  - Otherwise, count ← count ± 1 mod 2^`CNT_W` (wraps silently).
- `o_irq[c]` = flag[c] & `irq_en[c]`.
- Simultaneous events:
  - Bus write to COUNT or CTRL in the same cycle as a tick action: the bus write wins for the written register. Other side effects (flag set) still happen.
  - STATUS W1C in the same cycle as a match on that channel: the set wins, and the flag stays 1.
  - Enable written in a tick cycle: counting starts at the next tick.

## Timing
- Reads are combinational: `o_res_rd_data` and `o_res_code` are valid in the same cycle as the request and reflect the register state before that cycle's edge.
- Writes commit at the rising edge of the request cycle and are visible to reads from the next cycle.
- Match to flag: the flag and `o_irq` go high in the cycle after the tick edge (registered flag, combinational irq gating).
- Reset:
  - At a `reset` edge, all registers, `pc` and flags clear to 0, so `o_irq` = 0.
  - Bus writes in a reset cycle are discarded.
  - A reset asserted mid-count stops all channels immediately; no flag is set in that cycle.
- Reads issued while `reset` = 1 return the success code with the pre-edge data.

## Test plan
- Reset and bus checks:
  - After reset, read every valid word → all 0, success code.
  - Read k = 4·`N_CH`+2 → error code, data 0.
  - Sub-word write to CTRL → error code, CTRL unchanged.
- Free-run up, PRESCALE = 0:
  - COUNT = 2^`CNT_W`−2, CMP = 0, en = 1.
  - Required: count goes 0xFF..FE → 0xFF..FF → 0 → 1.
  - flag[0] sets on the tick where count = 0; `o_irq[0]` = 1 only if `irq_en` = 1.
- Periodic down, PRESCALE = 2:
  - LOAD = 5, COUNT = 5, CMP = 3.
  - Required: count changes every 3 cycles: 5, 4, 3, 5, 4, 3, 5.
  - flag sets on each return to 5.
- One-shot on channel 1:
  - LOAD = 10, COUNT = 8, CMP = 9, up.
  - Required: after 8→9→10, `en` reads 0 and count holds at 10.
  - Channel 0 continues counting unaffected.
- Simultaneous events:
  - Write COUNT = 7 in a match-tick cycle → count = 7 and flag = 1.
  - STATUS write 1 in a match cycle → flag stays 1.
  - STATUS write 1 in a later cycle → flag = 0 and `o_irq` = 0.
- Reset mid-count: assert `reset` for one cycle while channels run → all counts, CTRL and STATUS read 0 next cycle; no further ticks change count.

Source files
------------

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer: N_CH up/down counters with compare match,
// sticky W1C status flags, level interrupts and one shared prescaler.
module timer_bank #(
    parameter int unsigned ADDR_START  = 0,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned CNT_W       = WORD_W,
    parameter int unsigned PRESC_W     = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_COUNT_W = 4,
    parameter int unsigned MEM_CODE_W  = 2,
    parameter int unsigned CODE_OK     = 0,
    parameter int unsigned CODE_ERR    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [WORD_W-1:0]      i_req_wr_data,
    input  logic                   i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_req_count,
    output logic [WORD_W-1:0]      o_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_res_code,
    output logic [N_CH-1:0]        o_irq
);

    localparam int unsigned BPW     = WORD_W / 8;
    localparam int unsigned N_WORDS = 4 * N_CH + 2;
    localparam int unsigned KH_W    = ADDR_W - 2;

    logic [N_CH-1:0]    r_en;
    logic [N_CH-1:0]    r_down;
    logic [N_CH-1:0]    r_irq_en;
    logic [N_CH-1:0]    r_flag;
    logic [1:0]         r_mode [N_CH];
    logic [CNT_W-1:0]   r_load [N_CH];
    logic [CNT_W-1:0]   r_cmp  [N_CH];
    logic [CNT_W-1:0]   r_cnt  [N_CH];
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;

    logic [ADDR_W-1:0]  w_off;
    logic [ADDR_W-1:0]  w_k;
    logic [KH_W-1:0]    w_k_hi;
    logic               w_valid;
    logic               w_wr;
    logic               w_wr_status;
    logic               w_wr_presc;
    logic               w_tick;
    logic [N_CH-1:0]    w_wr_ctrl;
    logic [N_CH-1:0]    w_wr_load;
    logic [N_CH-1:0]    w_wr_cmp;
    logic [N_CH-1:0]    w_wr_cnt;
    logic [N_CH-1:0]    w_match;
    logic [CNT_W-1:0]   w_next [N_CH];

    // Address decode; addresses below ADDR_START wrap high and fall out of range.
    always_comb begin
        w_off       = i_req_addr - ADDR_W'(ADDR_START);
        w_k         = w_off / ADDR_W'(BPW);
        w_k_hi      = w_k[ADDR_W-1:2];
        w_valid     = (i_req_count == MEM_COUNT_W'(BPW))
                      && ((w_off % ADDR_W'(BPW)) == '0)
                      && (w_k < ADDR_W'(N_WORDS));
        w_wr        = w_valid && i_req_wr_en;
        w_wr_status = w_wr && (w_k == ADDR_W'(4 * N_CH));
        w_wr_presc  = w_wr && (w_k == ADDR_W'(4 * N_CH + 1));
        w_wr_ctrl   = '0;
        w_wr_load   = '0;
        w_wr_cmp    = '0;
        w_wr_cnt    = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_wr && (w_k_hi == KH_W'(c))) begin
                w_wr_ctrl[c] = (w_k[1:0] == 2'd0);
                w_wr_load[c] = (w_k[1:0] == 2'd1);
                w_wr_cmp[c]  = (w_k[1:0] == 2'd2);
                w_wr_cnt[c]  = (w_k[1:0] == 2'd3);
            end
        end
    end

    // Tick and per-channel next count; the match uses the pre-step count.
    always_comb begin
        w_tick = (r_pc == r_presc);
        for (int c = 0; c < N_CH; c++) begin
            w_match[c] = w_tick && r_en[c] && (r_cnt[c] == r_cmp[c]);
            if (w_match[c] && ((r_mode[c] == 2'd1) || (r_mode[c] == 2'd2))) begin
                w_next[c] = r_load[c];
            end else if (r_down[c]) begin
                w_next[c] = r_cnt[c] - CNT_W'(1);
            end else begin
                w_next[c] = r_cnt[c] + CNT_W'(1);
            end
        end
    end

    // Combinational read path over pre-edge register state.
    always_comb begin
        o_res_rd_data = '0;
        o_res_code    = MEM_CODE_W'(CODE_ERR);
        if (w_valid) begin
            o_res_code = MEM_CODE_W'(CODE_OK);
            for (int c = 0; c < N_CH; c++) begin
                if (w_k_hi == KH_W'(c)) begin
                    case (w_k[1:0])
                        2'd0:    o_res_rd_data = WORD_W'({r_irq_en[c], r_mode[c], r_down[c], r_en[c]});
                        2'd1:    o_res_rd_data = WORD_W'(r_load[c]);
                        2'd2:    o_res_rd_data = WORD_W'(r_cmp[c]);
                        default: o_res_rd_data = WORD_W'(r_cnt[c]);
                    endcase
                end
            end
            if (w_k == ADDR_W'(4 * N_CH)) begin
                o_res_rd_data = WORD_W'(r_flag);
            end
            if (w_k == ADDR_W'(4 * N_CH + 1)) begin
                o_res_rd_data = WORD_W'(r_presc);
            end
        end
    end

    assign o_irq = r_flag & r_irq_en;

    // Register state; a bus write overrides the tick action on the written register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= '0;
            r_down   <= '0;
            r_irq_en <= '0;
            r_flag   <= '0;
            r_presc  <= '0;
            r_pc     <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_mode[c] <= '0;
                r_load[c] <= '0;
                r_cmp[c]  <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            if (w_wr_presc) begin
                r_presc <= PRESC_W'(i_req_wr_data);
                r_pc    <= '0;
            end else if (w_tick) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + PRESC_W'(1);
            end
            for (int c = 0; c < N_CH; c++) begin
                if (w_match[c]) begin
                    r_flag[c] <= 1'b1;
                end else if (w_wr_status && i_req_wr_data[c]) begin
                    r_flag[c] <= 1'b0;
                end
                if (w_wr_ctrl[c]) begin
                    r_en[c]     <= i_req_wr_data[0];
                    r_down[c]   <= i_req_wr_data[1];
                    r_mode[c]   <= i_req_wr_data[3:2];
                    r_irq_en[c] <= i_req_wr_data[4];
                end else if (w_match[c] && (r_mode[c] == 2'd2)) begin
                    r_en[c] <= 1'b0;
                end
                if (w_wr_load[c]) begin
                    r_load[c] <= CNT_W'(i_req_wr_data);
                end
                if (w_wr_cmp[c]) begin
                    r_cmp[c] <= CNT_W'(i_req_wr_data);
                end
                if (w_wr_cnt[c]) begin
                    r_cnt[c] <= CNT_W'(i_req_wr_data);
                end else if (w_tick && r_en[c]) begin
                    r_cnt[c] <= w_next[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: expected bus responses are queued when a
// request is driven and popped/compared once the combinational response settles.
module tb_timer_bank;

    localparam logic [1:0]  OK     = 2'd0;
    localparam logic [1:0]  ERR    = 2'd1;
    localparam logic [31:0] CTRL0  = 32'h00;
    localparam logic [31:0] LOAD0  = 32'h04;
    localparam logic [31:0] CMP0   = 32'h08;
    localparam logic [31:0] CNT0   = 32'h0C;
    localparam logic [31:0] CTRL1  = 32'h10;
    localparam logic [31:0] LOAD1  = 32'h14;
    localparam logic [31:0] CMP1   = 32'h18;
    localparam logic [31:0] CNT1   = 32'h1C;
    localparam logic [31:0] STATUS = 32'h20;
    localparam logic [31:0] PRESC  = 32'h24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wr_data;
    logic        i_req_wr_en;
    logic [3:0]  i_req_count;
    logic [31:0] o_res_rd_data;
    logic [1:0]  o_res_code;
    logic [1:0]  o_irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_data [$];
    logic [1:0]  sb_code [$];
    string       sb_tag  [$];

    timer_bank #(
        .ADDR_START(0), .N_CH(2), .WORD_W(32), .CNT_W(32), .PRESC_W(16),
        .ADDR_W(32), .MEM_COUNT_W(4), .MEM_CODE_W(2), .CODE_OK(0), .CODE_ERR(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_addr   (i_req_addr),
        .i_req_wr_data(i_req_wr_data),
        .i_req_wr_en  (i_req_wr_en),
        .i_req_count  (i_req_count),
        .o_res_rd_data(o_res_rd_data),
        .o_res_code   (o_res_code),
        .o_irq        (o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req_addr    = '0;
        i_req_wr_data = '0;
        i_req_wr_en   = 1'b0;
        i_req_count   = 4'd4;
    endtask

    task automatic expect_rsp(input logic [31:0] data, input logic [1:0] code, input string tag);
        sb_data.push_back(data);
        sb_code.push_back(code);
        sb_tag.push_back(tag);
    endtask

    task automatic pop_cmp();
        logic [31:0] d;
        logic [1:0]  c;
        string       t;
        d = sb_data.pop_front();
        c = sb_code.pop_front();
        t = sb_tag.pop_front();
        check32({t, "_data"}, o_res_rd_data, d);
        check32({t, "_code"}, 32'(o_res_code), 32'(c));
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic [1:0] code,
                      input string tag);
        i_req_addr  = addr;
        i_req_wr_en = 1'b0;
        i_req_count = 4'd4;
        expect_rsp(exp, code, tag);
        #1;
        pop_cmp();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        i_req_addr    = addr;
        i_req_wr_data = data;
        i_req_wr_en   = 1'b1;
        i_req_count   = 4'd4;
        cyc();
        idle();
    endtask

    initial begin
        logic [31:0] pseq [7];
        pseq = '{32'd5, 32'd4, 32'd3, 32'd5, 32'd4, 32'd3, 32'd5};
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state and bus error handling
        for (int k = 0; k < 10; k++) begin
            rd(32'(k * 4), 32'h0, OK, $sformatf("rst_w%0d", k));
        end
        check32("rst_irq", 32'(o_irq), 32'h0);
        rd(32'h28, 32'h0, ERR, "oob_read");
        rd(32'h02, 32'h0, ERR, "misaligned_read");
        cyc();
        i_req_addr = CTRL0; i_req_wr_data = 32'h1F; i_req_wr_en = 1'b1; i_req_count = 4'd1;
        expect_rsp(32'h0, ERR, "subword_wr");
        #1;
        pop_cmp();
        cyc();
        idle();
        rd(CTRL0, 32'h0, OK, "ctrl_after_subword");

        // Free-run up with wrap, PRESCALE = 0
        wr(CNT0, 32'hFFFF_FFFE);
        wr(CTRL0, 32'h01);
        rd(CNT0, 32'hFFFF_FFFE, OK, "fr_c0");
        cyc();
        rd(CNT0, 32'hFFFF_FFFF, OK, "fr_c1");
        rd(STATUS, 32'h0, OK, "fr_st1");
        cyc();
        rd(CNT0, 32'h0, OK, "fr_c2");
        rd(STATUS, 32'h0, OK, "fr_st2");
        cyc();
        rd(CNT0, 32'h1, OK, "fr_c3");
        rd(STATUS, 32'h1, OK, "fr_st3");
        check32("fr_irq_masked", 32'(o_irq), 32'h0);
        wr(CTRL0, 32'h11);
        check32("fr_irq_en", 32'(o_irq), 32'h1);
        rd(CNT0, 32'h2, OK, "fr_c4");
        rd(CTRL0, 32'h11, OK, "fr_ctrl");
        wr(CTRL0, 32'h00);
        wr(STATUS, 32'h1);
        rd(STATUS, 32'h0, OK, "fr_w1c");
        check32("fr_irq_clr", 32'(o_irq), 32'h0);
        rd(CNT0, 32'h3, OK, "fr_held");

        // Periodic down, PRESCALE = 2
        wr(PRESC, 32'h2);
        wr(LOAD0, 32'd5);
        wr(CNT0, 32'd5);
        wr(CMP0, 32'd3);
        wr(CTRL0, 32'h07);
        for (int m = 0; m < 18; m++) begin
            rd(CNT0, pseq[(m + 1) / 3], OK, $sformatf("per_m%0d", m));
            if (m == 7 || m == 11 || m == 16) rd(STATUS, 32'h0, OK, $sformatf("per_st_m%0d", m));
            if (m == 8 || m == 17) rd(STATUS, 32'h1, OK, $sformatf("per_st_m%0d", m));
            if (m == 10) wr(STATUS, 32'h1);
            else cyc();
        end

        // One-shot on channel 1 while channel 0 free-runs
        wr(CTRL0, 32'h00);
        wr(PRESC, 32'h0);
        wr(STATUS, 32'h3);
        wr(LOAD1, 32'd10);
        wr(CMP1, 32'd9);
        wr(CNT1, 32'd8);
        wr(CNT0, 32'd100);
        wr(CTRL0, 32'h01);
        wr(CTRL1, 32'h09);
        rd(CNT1, 32'd8, OK, "os_c1_a");
        rd(CNT0, 32'd101, OK, "os_c0_a");
        cyc();
        rd(CNT1, 32'd9, OK, "os_c1_b");
        rd(CNT0, 32'd102, OK, "os_c0_b");
        cyc();
        rd(CNT1, 32'd10, OK, "os_c1_c");
        rd(CTRL1, 32'h08, OK, "os_ctrl1");
        rd(STATUS, 32'h2, OK, "os_status");
        cyc();
        rd(CNT1, 32'd10, OK, "os_c1_d");
        rd(CNT0, 32'd104, OK, "os_c0_d");
        check32("os_irq", 32'(o_irq), 32'h0);
        cyc();
        rd(CNT1, 32'd10, OK, "os_c1_e");
        rd(CNT0, 32'd105, OK, "os_c0_e");

        // Simultaneous bus/tick events on channel 1
        wr(CTRL0, 32'h00);
        wr(STATUS, 32'h3);
        wr(LOAD1, 32'd4);
        wr(CMP1, 32'd6);
        wr(CNT1, 32'd5);
        wr(CTRL1, 32'h15);
        cyc();
        rd(CNT1, 32'd6, OK, "sim_pre");
        wr(CNT1, 32'd7);
        rd(CNT1, 32'd7, OK, "sim_cnt_wins");
        rd(STATUS, 32'h2, OK, "sim_flag_set");
        check32("sim_irq_set", 32'(o_irq), 32'h2);
        wr(CMP1, 32'd9);
        wr(STATUS, 32'h2);
        rd(STATUS, 32'h0, OK, "sim_clr");
        rd(CNT1, 32'd9, OK, "sim_c9");
        check32("sim_irq_clr", 32'(o_irq), 32'h0);
        wr(STATUS, 32'h2);
        rd(STATUS, 32'h2, OK, "sim_set_wins");
        rd(CNT1, 32'd4, OK, "sim_reload");
        wr(STATUS, 32'h2);
        rd(STATUS, 32'h0, OK, "sim_later_clr");
        check32("sim_irq_later", 32'(o_irq), 32'h0);
        rd(CNT1, 32'd5, OK, "sim_c5");

        // Reset mid-count with a discarded bus write
        wr(CTRL0, 32'h01);
        reset = 1'b1;
        rd(CTRL1, 32'h15, OK, "rd_in_reset");
        i_req_addr = CNT1; i_req_wr_data = 32'h55; i_req_wr_en = 1'b1; i_req_count = 4'd4;
        cyc();
        reset = 1'b0;
        idle();
        rd(CNT0, 32'h0, OK, "mr_cnt0");
        rd(CNT1, 32'h0, OK, "mr_cnt1");
        rd(CTRL0, 32'h0, OK, "mr_ctrl0");
        rd(CTRL1, 32'h0, OK, "mr_ctrl1");
        rd(STATUS, 32'h0, OK, "mr_status");
        rd(PRESC, 32'h0, OK, "mr_presc");
        check32("mr_irq", 32'(o_irq), 32'h0);
        cyc();
        cyc();
        rd(CNT0, 32'h0, OK, "mr_cnt0_hold");
        rd(CNT1, 32'h0, OK, "mr_cnt1_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
